x86_inst_decoder: RTL and testbench



---
 rtl/x86_dec_pkg.sv | 45 ++++
 rtl/x86_opcode_tables.sv | 82 ++++++++
 rtl/x86_inst_decoder.sv | 156 +++++++++++++++
 tb/tb_x86_inst_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/x86_dec_pkg.sv
// Shared types, prefix constants and ASCII helpers for the x86-64 length/mnemonic decoder.
package x86_dec_pkg;

    typedef logic [63:0] mnemonic_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_IB   = 3'd1,
        IMM_IW   = 3'd2,
        IMM_IZ   = 3'd3,
        IMM_IV   = 3'd4,
        IMM_IWIB = 3'd5
    } imm_class_e;

    typedef struct packed {
        mnemonic_t  name;
        logic       has_modrm;
        imm_class_e imm;
    } op_entry_t;

    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
    localparam logic [7:0] PFX_LOCK     = 8'hF0;
    localparam logic [7:0] PFX_REPNE    = 8'hF2;
    localparam logic [7:0] PFX_REP      = 8'hF3;
    localparam logic [7:0] PFX_ES       = 8'h26;
    localparam logic [7:0] PFX_CS       = 8'h2E;
    localparam logic [7:0] PFX_SS       = 8'h36;
    localparam logic [7:0] PFX_DS       = 8'h3E;
    localparam logic [7:0] PFX_FS       = 8'h64;
    localparam logic [7:0] PFX_GS       = 8'h65;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam mnemonic_t  BAD_MNEM    = {"(bad)", 24'h0};

    function automatic logic is_legacy_prefix(input logic [7:0] b);
        return b inside {PFX_OPSIZE, PFX_ADDRSIZE, PFX_LOCK, PFX_REPNE, PFX_REP,
                         PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_FS, PFX_GS};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

endpackage

// File: rtl/x86_opcode_tables.sv
// Constant opcode tables: mnemonics and ModRM flags for the one-byte and 0F maps, plus
// immediate-class info for the one-byte map. Zero mnemonic marks an unmapped opcode.
module x86_opcode_tables
    import x86_dec_pkg::*;
(
    output mnemonic_t    op          [256],
    output mnemonic_t    op2         [256],
    output logic [255:0] modrm,
    output logic [255:0] modrm2,
    output logic [22:0]  instrn_info [256]
);

    function automatic op_entry_t ent(input mnemonic_t n, input logic m, input imm_class_e i);
        return '{name: n, has_modrm: m, imm: i};
    endfunction

    function automatic op_entry_t map1_entry(input logic [7:0] b);
        op_entry_t e;
        e = ent('0, 1'b0, IMM_NONE);
        case (b) inside
            8'h01, 8'h03:   e = ent({"add", 40'h0}, 1'b1, IMM_NONE);
            8'h05:          e = ent({"add", 40'h0}, 1'b0, IMM_IZ);
            8'h29, 8'h2B:   e = ent({"sub", 40'h0}, 1'b1, IMM_NONE);
            8'h31, 8'h33:   e = ent({"xor", 40'h0}, 1'b1, IMM_NONE);
            8'h39, 8'h3B:   e = ent({"cmp", 40'h0}, 1'b1, IMM_NONE);
            8'h3D:          e = ent({"cmp", 40'h0}, 1'b0, IMM_IZ);
            [8'h50:8'h57]:  e = ent({"push", 32'h0}, 1'b0, IMM_NONE);
            [8'h58:8'h5F]:  e = ent({"pop", 40'h0}, 1'b0, IMM_NONE);
            8'h68:          e = ent({"push", 32'h0}, 1'b0, IMM_IZ);
            8'h6A:          e = ent({"push", 32'h0}, 1'b0, IMM_IB);
            [8'h70:8'h7F]:  e = ent({"jcc", 40'h0}, 1'b0, IMM_IB);
            8'h81:          e = ent({"grp1", 32'h0}, 1'b1, IMM_IZ);
            8'h83:          e = ent({"grp1", 32'h0}, 1'b1, IMM_IB);
            8'h85:          e = ent({"test", 32'h0}, 1'b1, IMM_NONE);
            8'h89, 8'h8B:   e = ent({"mov", 40'h0}, 1'b1, IMM_NONE);
            8'h8D:          e = ent({"lea", 40'h0}, 1'b1, IMM_NONE);
            8'h90:          e = ent({"nop", 40'h0}, 1'b0, IMM_NONE);
            [8'hB0:8'hB7]:  e = ent({"mov", 40'h0}, 1'b0, IMM_IB);
            [8'hB8:8'hBF]:  e = ent({"mov", 40'h0}, 1'b0, IMM_IV);
            8'hC2:          e = ent({"ret", 40'h0}, 1'b0, IMM_IW);
            8'hC3:          e = ent({"ret", 40'h0}, 1'b0, IMM_NONE);
            8'hC7:          e = ent({"mov", 40'h0}, 1'b1, IMM_IZ);
            8'hC8:          e = ent({"enter", 24'h0}, 1'b0, IMM_IWIB);
            8'hC9:          e = ent({"leave", 24'h0}, 1'b0, IMM_NONE);
            8'hCC:          e = ent({"int3", 32'h0}, 1'b0, IMM_NONE);
            8'hE8:          e = ent({"call", 32'h0}, 1'b0, IMM_IZ);
            8'hE9:          e = ent({"jmp", 40'h0}, 1'b0, IMM_IZ);
            8'hEB:          e = ent({"jmp", 40'h0}, 1'b0, IMM_IB);
            8'hF4:          e = ent({"hlt", 40'h0}, 1'b0, IMM_NONE);
            8'hF6:          e = ent({"grp3", 32'h0}, 1'b1, IMM_IB);
            8'hF7:          e = ent({"grp3", 32'h0}, 1'b1, IMM_IZ);
            8'hFF:          e = ent({"grp5", 32'h0}, 1'b1, IMM_NONE);
            default:        e = ent('0, 1'b0, IMM_NONE);
        endcase
        return e;
    endfunction

    function automatic op_entry_t map2_entry(input logic [7:0] b);
        op_entry_t e;
        e = ent('0, 1'b0, IMM_NONE);
        case (b)
            8'h05:        e = ent({"syscall", 8'h0}, 1'b0, IMM_NONE);
            8'h0B:        e = ent({"ud2", 40'h0}, 1'b0, IMM_NONE);
            8'h1F:        e = ent({"nop", 40'h0}, 1'b1, IMM_NONE);
            8'h31:        e = ent({"rdtsc", 24'h0}, 1'b0, IMM_NONE);
            8'hA2:        e = ent({"cpuid", 24'h0}, 1'b0, IMM_NONE);
            8'hAF:        e = ent({"imul", 32'h0}, 1'b1, IMM_NONE);
            8'hB6, 8'hB7: e = ent({"movzx", 24'h0}, 1'b1, IMM_NONE);
            default:      e = ent('0, 1'b0, IMM_NONE);
        endcase
        return e;
    endfunction

    for (genvar i = 0; i < 256; i++) begin : g_tab
        assign op[i]          = map1_entry(8'(i)).name;
        assign modrm[i]       = map1_entry(8'(i)).has_modrm;
        assign instrn_info[i] = {20'h0, map1_entry(8'(i)).imm};
        assign op2[i]         = map2_entry(8'(i)).name;
        assign modrm2[i]      = map2_entry(8'(i)).has_modrm;
    end

endmodule

// File: rtl/x86_inst_decoder.sv
// Single-cycle x86-64 instruction length decoder with registered ASCII trace record.
// Optional DECODER_TRACE_EN prints each trace record during simulation.
module x86_inst_decoder
    import x86_dec_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic [0:119] decode_bytes,
    input  logic [63:0]  current_addr,
    output logic [3:0]   bytes_decoded,
    output logic         out_valid,
    output logic [63:0]  out_addr,
    output logic [191:0] opcode_stream,
    output logic [255:0] mnemonic_stream
);

    mnemonic_t    op_tab   [256];
    mnemonic_t    op2_tab  [256];
    logic [255:0] modrm_tab;
    logic [255:0] modrm2_tab;
    logic [22:0]  info_tab [256];

    x86_opcode_tables u_tables (
        .op          (op_tab),
        .op2         (op2_tab),
        .modrm       (modrm_tab),
        .modrm2      (modrm2_tab),
        .instrn_info (info_tab)
    );

    // Byte 15 is a zero pad so indices past the window stay in range.
    logic [7:0] win [16];
    for (genvar i = 0; i < 15; i++) begin : g_win
        assign win[i] = decode_bytes[i*8 +: 8];
    end
    assign win[15] = 8'h00;

    logic [2:0]   npfx;
    logic         pfx_stop, opsize16, rex_w, rex_bad, map2, has_modrm, bad;
    logic [3:0]   pos, op_len, mrm_len, imm_len, shown;
    logic [7:0]   opc, modrm_b, ch;
    logic [2:0]   sib_base;
    logic [22:0]  info;
    imm_class_e   imm;
    mnemonic_t    mnem, name;
    logic [4:0]   total;
    logic [191:0] ostr;
    logic [255:0] mstr;

    always_comb begin
        npfx     = 3'd0;
        pfx_stop = 1'b0;
        opsize16 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!pfx_stop && is_legacy_prefix(win[i])) begin
                npfx = npfx + 3'd1;
                if (win[i] == PFX_OPSIZE) opsize16 = 1'b1;
            end else begin
                pfx_stop = 1'b1;
            end
        end

        pos     = {1'b0, npfx};
        rex_w   = 1'b0;
        rex_bad = 1'b0;
        if (win[pos][7:4] == 4'h4) begin
            rex_w   = win[pos][3];
            rex_bad = is_legacy_prefix(win[pos + 4'd1]);
            pos     = pos + 4'd1;
        end

        map2      = (win[pos] == 8'h0F);
        opc       = map2 ? win[pos + 4'd1] : win[pos];
        op_len    = map2 ? 4'd2 : 4'd1;
        mnem      = map2 ? op2_tab[opc] : op_tab[opc];
        has_modrm = map2 ? modrm2_tab[opc] : modrm_tab[opc];
        info      = map2 ? 23'h0 : info_tab[opc];
        imm       = imm_class_e'(info[2:0]);
        modrm_b   = win[pos + op_len];
        sib_base  = win[pos + op_len + 4'd1][2:0];

        mrm_len = 4'd0;
        if (has_modrm) begin
            mrm_len = 4'd1;
            if (modrm_b[7:6] != 2'b11 && modrm_b[2:0] == 3'b100) begin
                mrm_len = mrm_len + 4'd1;
                if (modrm_b[7:6] == 2'b00 && sib_base == 3'b101) mrm_len = mrm_len + 4'd4;
            end
            case (modrm_b[7:6])
                2'b00:   if (modrm_b[2:0] == 3'b101) mrm_len = mrm_len + 4'd4;
                2'b01:   mrm_len = mrm_len + 4'd1;
                2'b10:   mrm_len = mrm_len + 4'd4;
                default: mrm_len = mrm_len;
            endcase
        end

        // Group 3 (F6/F7): only the TEST form (reg=000) carries an immediate.
        if (!map2 && (opc == 8'hF6 || opc == 8'hF7) && modrm_b[5:3] != 3'b000) imm = IMM_NONE;

        case (imm)
            IMM_IB:   imm_len = 4'd1;
            IMM_IW:   imm_len = 4'd2;
            IMM_IZ:   imm_len = opsize16 ? 4'd2 : 4'd4;
            IMM_IV:   imm_len = rex_w ? 4'd8 : (opsize16 ? 4'd2 : 4'd4);
            IMM_IWIB: imm_len = 4'd3;
            default:  imm_len = 4'd0;
        endcase

        total = {1'b0, pos} + {1'b0, op_len} + {1'b0, mrm_len} + {1'b0, imm_len};
        bad   = (mnem == '0) || (npfx > 3'd4) || rex_bad || (total > 5'd15) || (|info[22:3]);
        bytes_decoded = !valid_in ? 4'd0 : (bad ? 4'd1 : total[3:0]);
        name  = bad ? BAD_MNEM : mnem;

        shown = (bytes_decoded > 4'd8) ? 4'd8 : bytes_decoded;
        ostr  = {24{ASCII_SPACE}};
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < shown) begin
                ostr[191 - 24*k -: 8] = hex_char(win[k][7:4]);
                ostr[183 - 24*k -: 8] = hex_char(win[k][3:0]);
            end
        end

        ch   = 8'h00;
        mstr = {32{ASCII_SPACE}};
        for (int j = 0; j < 8; j++) begin
            ch = name[63 - 8*j -: 8];
            mstr[255 - 8*j -: 8] = (ch == 8'h00) ? ASCII_SPACE : ch;
        end
    end

    // Trace record register: captured only on valid cycles, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_addr        <= '0;
            opcode_stream   <= {24{ASCII_SPACE}};
            mnemonic_stream <= {32{ASCII_SPACE}};
        end else begin
            out_valid <= valid_in;
            if (valid_in) begin
                out_addr        <= current_addr;
                opcode_stream   <= ostr;
                mnemonic_stream <= mstr;
            end
        end
    end

`ifdef DECODER_TRACE_EN
    always @(posedge clk) begin
        if (out_valid) $display("%x: %s %s", out_addr, opcode_stream, mnemonic_stream);
    end
`else
`endif

endmodule

// File: tb/tb_x86_inst_decoder.sv
// Scoreboard bench for x86_inst_decoder: hand-derived lengths and mnemonics per vector.
module tb_x86_inst_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [0:119] decode_bytes;
    logic [63:0]  current_addr;
    logic [3:0]   bytes_decoded;
    logic         out_valid;
    logic [63:0]  out_addr;
    logic [191:0] opcode_stream;
    logic [255:0] mnemonic_stream;

    x86_inst_decoder dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .decode_bytes    (decode_bytes),
        .current_addr    (current_addr),
        .bytes_decoded   (bytes_decoded),
        .out_valid       (out_valid),
        .out_addr        (out_addr),
        .opcode_stream   (opcode_stream),
        .mnemonic_stream (mnemonic_stream)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         valid;
        logic [63:0]  addr;
        logic [191:0] ostr;
        logic [255:0] mstr;
    } rec_t;

    rec_t        sb [$];
    rec_t        held;
    logic [7:0]  bq [$];
    logic [63:0] next_addr = 64'h0000_7fff_0040_1000;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] exp_ostr(input int n);
        string s;
        logic [191:0] v;
        s = "";
        for (int i = 0; i < n && i < 8; i++) s = {s, $sformatf("%02x ", bq[i])};
        v = '0;
        for (int k = 0; k < 24; k++) v[191 - 8*k -: 8] = (k < s.len()) ? s[k] : 8'h20;
        return v;
    endfunction

    function automatic logic [255:0] exp_mstr(input string m);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) v[255 - 8*k -: 8] = (k < m.len()) ? m[k] : 8'h20;
        return v;
    endfunction

    task automatic expect_out(input string tag);
        rec_t r;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb: got empty scoreboard expected one record", tag);
        end else begin
            r = sb.pop_front();
            check_eq({tag, "_vld"},  256'(out_valid), 256'(r.valid));
            check_eq({tag, "_addr"}, 256'(out_addr), 256'(r.addr));
            check_eq({tag, "_ostr"}, 256'(opcode_stream), 256'(r.ostr));
            check_eq({tag, "_mstr"}, mnemonic_stream, r.mstr);
        end
    endtask

    task automatic load_window();
        for (int i = 0; i < 15; i++)
            decode_bytes[i*8 +: 8] = (i < bq.size()) ? bq[i] : 8'($urandom_range(0, 255));
    endtask

    task automatic run(input string tag, input int exp_len, input string mn);
        rec_t r;
        @(negedge clk);
        valid_in     = 1'b1;
        current_addr = next_addr;
        load_window();
        #1 check_eq({tag, "_len"}, 256'(bytes_decoded), 256'(exp_len));
        r.valid = 1'b1;
        r.addr  = next_addr;
        r.ostr  = exp_ostr(exp_len);
        r.mstr  = exp_mstr(mn);
        sb.push_back(r);
        held = r;
        next_addr = next_addr + 64'(exp_len);
        @(posedge clk);
        #1 expect_out(tag);
    endtask

    task automatic idle(input string tag);
        rec_t r;
        @(negedge clk);
        valid_in = 1'b0;
        bq = '{8'h55};
        load_window();
        current_addr = 64'hdead_beef_0000_0000;
        #1 check_eq({tag, "_len"}, 256'(bytes_decoded), 256'(0));
        r = held;
        r.valid = 1'b0;
        sb.push_back(r);
        @(posedge clk);
        #1 expect_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        valid_in     = 1'b0;
        decode_bytes = '0;
        current_addr = '0;
        held = '{valid: 1'b0, addr: 64'h0, ostr: {24{8'h20}}, mstr: {32{8'h20}}};
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(held);
        expect_out("rst");
        @(negedge clk) reset = 1'b0;

        bq = '{8'h55};                                  run("push",     1, "push");
        bq = '{8'h48, 8'h89, 8'he5};                    run("movrr",    3, "mov");
        bq = '{8'h48, 8'hc7, 8'h45, 8'hf8, 8'h01, 8'h00, 8'h00, 8'h00};
                                                        run("movimm",   8, "mov");
        bq = '{8'h66, 8'hb8, 8'h34, 8'h12};             run("mov16",    4, "mov");
        bq = '{8'h48, 8'hb8, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
                                                        run("movabs",  10, "mov");
        bq = '{8'h8b, 8'h04, 8'h25, 8'h00, 8'h10, 8'h00, 8'h00};
                                                        run("sib",      7, "mov");
        bq = '{8'h8b, 8'h80, 8'h00, 8'h01, 8'h00, 8'h00};
                                                        run("disp32",   6, "mov");
        bq = '{8'h0f, 8'h05};                           run("syscall",  2, "syscall");
        bq = '{8'hf6, 8'hc0, 8'h01};                    run("grp3ib",   3, "grp3");
        bq = '{8'hf6, 8'hd0};                           run("grp3not",  2, "grp3");
        bq = '{8'hc8, 8'h10, 8'h00, 8'h01};             run("enter",    4, "enter");
        bq = '{8'h66, 8'hc7, 8'h00, 8'h34, 8'h12};      run("iz16",     5, "mov");
        bq = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h90};      run("pfx4",     5, "nop");
        bq = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h90};
                                                        run("pfx5",     1, "(bad)");
        bq = '{8'h06, 8'h00};                           run("unmapped", 1, "(bad)");
        bq = '{8'h48, 8'h66, 8'h90};                    run("rexpfx",   1, "(bad)");
        bq = '{8'hf3, 8'hf3, 8'hf3, 8'hf3, 8'h48, 8'h81, 8'h84, 8'h24,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
                                                        run("toolong",  1, "(bad)");

        idle("idle0");
        idle("idle1");
        bq = '{8'he8, 8'h00, 8'h00, 8'h00, 8'h00};      run("call",     5, "call");

        // Reset with valid_in high: length still reported, record cleared.
        @(negedge clk);
        reset        = 1'b1;
        valid_in     = 1'b1;
        current_addr = next_addr;
        bq = '{8'h48, 8'h89, 8'he5};
        load_window();
        #1 check_eq("rstmid_len", 256'(bytes_decoded), 256'(3));
        held = '{valid: 1'b0, addr: 64'h0, ostr: {24{8'h20}}, mstr: {32{8'h20}}};
        sb.push_back(held);
        @(posedge clk);
        #1 expect_out("rstmid");
        @(negedge clk) reset = 1'b0;

        bq = '{8'hc3};                                  run("ret",      1, "ret");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
